// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and helpers for the multi-cycle wide adder sequencer.
package wide_add_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Slice index width; a single-slice build still needs one bit.
   function automatic int idx_width(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake plus the external n-bit adder slice connection.
interface wide_add_sequencer_if #(
   parameter int N = 8,
   parameter int K = 4
);
   localparam int W = N * K;

   logic         in_valid;
   logic         in_ready;
   logic         cin;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         cout;
   logic         prop_all;
   logic         gen_all;
   logic [N-1:0] add_a;
   logic [N-1:0] add_b;
   logic         add_cin;
   logic [N-1:0] add_s;
   logic         add_cout;
   logic         add_prop;
   logic         add_gen;

   modport slave (
      input  in_valid, cin, a, b, out_ready, add_s, add_cout, add_prop, add_gen,
      output in_ready, out_valid, s, cout, prop_all, gen_all, add_a, add_b, add_cin
   );

   modport master (
      output in_valid, cin, a, b, out_ready, add_s, add_cout, add_prop, add_gen,
      input  in_ready, out_valid, s, cout, prop_all, gen_all, add_a, add_b, add_cin
   );

endinterface

// File: rtl/wide_add_sequencer_fsm.sv
// Sequencer control: state register, slice index counter, handshake flags.
module wide_add_seq_fsm
   import wide_add_sequencer_pkg::*;
#(
   parameter int K    = 4,
   parameter int IDXW = idx_width(K)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic            out_ready,
   output state_t          state,
   output logic [IDXW-1:0] idx,
   output logic            in_ready,
   output logic            accept,
   output logic            last,
   output logic            out_valid
);

   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(K - 1);

   // A new operation may enter while the previous result is being taken.
   assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
   assign accept   = in_valid & in_ready;
   assign last     = (state == RUN) & (idx == IDX_LAST);

   // State, slice counter and result-valid register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= {IDXW{1'b0}};
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= RUN;
                  idx   <= {IDXW{1'b0}};
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (idx == IDX_LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  idx <= idx + IDXW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     state <= RUN;
                     idx   <= {IDXW{1'b0}};
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  state <= DONE;
               end
            end
            default: begin
               state     <= IDLE;
               idx       <= {IDXW{1'b0}};
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/wide_add_sequencer.sv
// W=N*K-bit adder built by driving one external N-bit slice K times, LSB first,
// chaining carry and merging group propagate/generate across slices.
module wide_add_sequencer
   import wide_add_sequencer_pkg::*;
#(
   parameter int N = 8,
   parameter int K = 4
) (
   input logic                clk,
   input logic                rst_n,
   wide_add_sequencer_if.slave bus
);

   localparam int W    = N * K;
   localparam int IDXW = idx_width(K);

   state_t          state_s;
   logic [IDXW-1:0] idx_s;
   logic            accept_s;
   logic            last_s;
   logic            in_ready_s;
   logic            out_valid_s;
   logic            first_s;

   logic [W-1:0]    a_r;
   logic [W-1:0]    b_r;
   logic            cin_r;
   logic [W-1:0]    s_r;
   logic            carry_r;
   logic            cout_r;
   logic            prop_r;
   logic            gen_r;

   wide_add_seq_fsm #(.K(K), .IDXW(IDXW)) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (bus.in_valid),
      .out_ready (bus.out_ready),
      .state     (state_s),
      .idx       (idx_s),
      .in_ready  (in_ready_s),
      .accept    (accept_s),
      .last      (last_s),
      .out_valid (out_valid_s)
   );

   assign first_s = (idx_s == {IDXW{1'b0}});

   // Operand capture and slice-by-slice result accumulation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_r     <= {W{1'b0}};
         b_r     <= {W{1'b0}};
         cin_r   <= 1'b0;
         s_r     <= {W{1'b0}};
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         prop_r  <= 1'b0;
         gen_r   <= 1'b0;
      end else begin
         if (accept_s) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            cin_r <= bus.cin;
         end
         if (state_s == RUN) begin
            s_r[idx_s*N +: N] <= bus.add_s;
            carry_r           <= bus.add_cout;
            if (first_s) begin
               prop_r <= bus.add_prop;
               gen_r  <= bus.add_gen;
            end else begin
               prop_r <= prop_r & bus.add_prop;
               gen_r  <= bus.add_gen | (bus.add_prop & gen_r);
            end
            if (last_s) begin
               cout_r <= bus.add_cout;
            end
         end
      end
   end

   // Slice operands come straight from the latched registers, so never X.
   assign bus.add_a     = a_r[idx_s*N +: N];
   assign bus.add_b     = b_r[idx_s*N +: N];
   assign bus.add_cin   = first_s ? cin_r : carry_r;

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.s         = s_r;
   assign bus.cout      = cout_r;
   assign bus.prop_all  = prop_r;
   assign bus.gen_all   = gen_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and random checks of wide_add_sequencer with a behavioural 8-bit slice.
module tb_wide_add_sequencer;

   localparam int N = 8;
   localparam int K = 4;
   localparam int W = N * K;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   wide_add_sequencer_if #(.N(N), .K(K)) bus ();

   wide_add_sequencer #(.N(N), .K(K)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural slice standing in for the characterised n-bit adder.
   logic [N:0] slice_ab;
   assign slice_ab = {1'b0, bus.add_a} + {1'b0, bus.add_b};
   assign {bus.add_cout, bus.add_s} = slice_ab + {{N{1'b0}}, bus.add_cin};
   assign bus.add_prop = &(bus.add_a ^ bus.add_b);
   assign bus.add_gen  = slice_ab[N];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         cout;
      logic         prop;
      logic         gen;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
      int g;
      @(negedge clk);
      bus.a        = ta;
      bus.b        = tb_v;
      bus.cin      = tc;
      bus.in_valid = 1'b1;
      g = 0;
      while (!bus.in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.out_valid && lat < 20);
   endtask

   task automatic release_result();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("release_clears_valid", {63'd0, bus.out_valid}, 64'd0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [W:0]  ref_sum;
      logic [W:0]  ref_ab;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic        rc;
      logic        saw_valid;

      checks   = 0;
      failures = 0;
      vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("reset_in_ready",  {63'd0, bus.in_ready},  64'd1);
      chk("reset_s",         {32'd0, bus.s},         64'd0);
      chk("reset_cout",      {63'd0, bus.cout},      64'd0);
      chk("reset_prop_gen",  {62'd0, bus.prop_all, bus.gen_all}, 64'd0);

      for (int i = 0; i < 9; i++) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
         wait_result(lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
         chk($sformatf("vec%0d_s", i),    {32'd0, bus.s},        {32'd0, vecs[i].s});
         chk($sformatf("vec%0d_cout", i), {63'd0, bus.cout},     {63'd0, vecs[i].cout});
         chk($sformatf("vec%0d_prop", i), {63'd0, bus.prop_all}, {63'd0, vecs[i].prop});
         chk($sformatf("vec%0d_gen", i),  {63'd0, bus.gen_all},  {63'd0, vecs[i].gen});
         chk($sformatf("vec%0d_invariant", i), {63'd0, bus.cout},
             {63'd0, bus.gen_all | (bus.prop_all & vecs[i].cin)});
         release_result();
      end

      // Stall in DONE: result held, no new operands accepted.
      start_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
      wait_result(lat);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("stall_valid",    {63'd0, bus.out_valid}, 64'd1);
         chk("stall_s",        {32'd0, bus.s},         64'h0000_0000_1010_1010);
         chk("stall_cout",     {63'd0, bus.cout},      64'd0);
         chk("stall_in_ready", {63'd0, bus.in_ready},  64'd0);
      end
      release_result();

      // Back-to-back with in_valid and out_ready both held high.
      @(negedge clk);
      bus.a = 32'h1; bus.b = 32'h1; bus.cin = 1'b0;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.a = 32'h8000_0000; bus.b = 32'h8000_0000;
      wait_result(lat);
      chk("b2b_first_latency", 64'(lat), 64'd4);
      chk("b2b_first_s",    {32'd0, bus.s},    64'd2);
      chk("b2b_first_cout", {63'd0, bus.cout}, 64'd0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("b2b_valid_drops", {63'd0, bus.out_valid}, 64'd0);
      wait_result(lat);
      chk("b2b_period", 64'(lat + 1), 64'd5);
      chk("b2b_second_s",    {32'd0, bus.s},    64'd0);
      chk("b2b_second_cout", {63'd0, bus.cout}, 64'd1);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("b2b_final_release", {63'd0, bus.out_valid}, 64'd0);

      // Reset while RUN at idx=2 discards the operation.
      start_op(32'h1111_1111, 32'h2222_2222, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_in_ready",  {63'd0, bus.in_ready},  64'd1);
      chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("abort_s",         {32'd0, bus.s},         64'd0);
      saw_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (bus.out_valid) saw_valid = 1'b1;
      end
      chk("abort_never_output", {63'd0, saw_valid}, 64'd0);

      // Random operands against a W-bit reference adder.
      for (int r = 0; r < 200; r++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         ref_ab  = {1'b0, ra} + {1'b0, rb};
         ref_sum = ref_ab + {{W{1'b0}}, rc};
         start_op(ra, rb, rc);
         wait_result(lat);
         chk("rand_sum", {31'd0, bus.cout, bus.s}, {31'd0, ref_sum});
         chk("rand_prop_gen", {62'd0, bus.prop_all, bus.gen_all},
             {62'd0, &(ra ^ rb), ref_ab[W]});
         release_result();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
